alu_arbiter: RTL and testbench

//  Shares one 16-bit alu instance (op, i0, i1 -> o, cout) between two requesters.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu.sv | 30 +++
 rtl/rr_arb2.sv | 21 ++
 rtl/alu_arbiter.sv | 171 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU arbiter slice: datapath widths, ALU op codes
// and the arbiter FSM encoding.
package alu_pkg;

    localparam int WIDTH = 16;
    localparam int OPW   = 2;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } arb_state_t;

endpackage

// File: rtl/alu.sv
// Combinational 16-bit ALU: add, subtract, and, xor. For subtract, cout is
// the carry of i0 + ~i1 + 1, i.e. high when no borrow occurs.
module alu #(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int OPW   = alu_pkg::OPW
) (
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    output logic [WIDTH-1:0] o,
    output logic             cout
);
    import alu_pkg::*;

    logic [WIDTH:0] sum;

    always_comb begin
        sum = '0;
        case (op)
            OP_ADD:  sum = {1'b0, i0} + {1'b0, i1};
            OP_SUB:  sum = {1'b0, i0} + {1'b0, ~i1} + {{WIDTH{1'b0}}, 1'b1};
            OP_AND:  sum = {1'b0, i0 & i1};
            default: sum = {1'b0, i0 ^ i1};
        endcase
    end

    assign o    = sum[WIDTH-1:0];
    assign cout = sum[WIDTH];

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// requester that was not granted last. Grant is one-hot, all-zero when disabled.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (valid == 2'b11) begin
                grant = last_grant ? 2'b01 : 2'b10;
            end else begin
                grant = valid;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with round-robin arbitration, one op in
// flight. Optional per-requester grant counters under macro ALU_ARB_STATS_EN.
module alu_arbiter #(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int OPW   = alu_pkg::OPW,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp0_cout,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             rsp1_cout,
`ifdef ALU_ARB_STATS_EN
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1,
`endif
    output logic [1:0]       dbg_state
);
    import alu_pkg::*;

    // Handshake: a request transfers on the edge where valid && ready; a
    // response transfers on the edge where rsp valid && rsp ready.
    arb_state_t       state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic             gnt_q, gnt_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             cout_q, cout_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;

    logic [1:0]       grant;
    logic             accept0, accept1, drain;
    logic [WIDTH-1:0] alu_o;
    logic             alu_cout;

    // Gating with reset keeps both readies low while reset is asserted.
    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .enable     ((state_q == IDLE) && reset),
        .grant      (grant)
    );

    alu #(.WIDTH(WIDTH), .OPW(OPW)) u_alu (
        .op   (op_q),
        .i0   (a_q),
        .i1   (b_q),
        .o    (alu_o),
        .cout (alu_cout)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign accept0    = req0_valid & grant[0];
    assign accept1    = req1_valid & grant[1];
    assign drain      = (state_q == RESP) && (gnt_q ? rsp1_ready : rsp0_ready);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        data_d       = data_q;
        cout_d       = cout_q;
        rsp_valid_d  = rsp_valid_q;
        case (state_q)
            IDLE: begin
                if (accept0 || accept1) begin
                    state_d      = EXEC;
                    gnt_d        = accept1;
                    last_grant_d = accept1;
                    op_d         = accept1 ? req1_op : req0_op;
                    a_d          = accept1 ? req1_a  : req0_a;
                    b_d          = accept1 ? req1_b  : req0_b;
                end
            end
            EXEC: begin
                state_d     = RESP;
                data_d      = alu_o;
                cout_d      = alu_cout;
                rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
            end
            RESP: begin
                if (drain) begin
                    state_d     = IDLE;
                    rsp_valid_d = 2'b00;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            data_q       <= '0;
            cout_q       <= 1'b0;
            rsp_valid_q  <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            data_q       <= data_d;
            cout_q       <= cout_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp0_data  = data_q;
    assign rsp1_data  = data_q;
    assign rsp0_cout  = cout_q;
    assign rsp1_cout  = cout_q;
    assign dbg_state  = state_q;

`ifdef ALU_ARB_STATS_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (accept0 && (cnt0_q != '1)) cnt0_d = cnt0_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (accept1 && (cnt1_q != '1)) cnt1_d = cnt1_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`else
    logic [CNT_W-1:0] cnt_unused;
    assign cnt_unused = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic checked each
// cycle against a transaction-level reference model (ALU_ARB_STATS_EN optional).
module tb_alu_arbiter;
    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic           v[2];
    logic           rr[2];
    logic [1:0]     opv[2];
    logic [W-1:0]   av[2];
    logic [W-1:0]   bv[2];

    logic           req0_ready, req1_ready;
    logic           rsp0_valid, rsp1_valid;
    logic [W-1:0]   rsp0_data, rsp1_data;
    logic           rsp0_cout, rsp1_cout;
    logic [1:0]     dbg_state;
`ifdef ALU_ARB_STATS_EN
    logic [15:0]    cnt0, cnt1;
    logic [1:0]     sat_cnt0, sat_cnt1;
    logic           sat_rdy0, sat_rdy1, sat_rv0, sat_rv1, sat_c0, sat_c1;
    logic [W-1:0]   sat_d0, sat_d1;
    logic [1:0]     sat_dbg;
`endif

    alu_arbiter u_dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (v[0]),
        .req0_ready (req0_ready),
        .req0_op    (opv[0]),
        .req0_a     (av[0]),
        .req0_b     (bv[0]),
        .req1_valid (v[1]),
        .req1_ready (req1_ready),
        .req1_op    (opv[1]),
        .req1_a     (av[1]),
        .req1_b     (bv[1]),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rr[0]),
        .rsp0_data  (rsp0_data),
        .rsp0_cout  (rsp0_cout),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rr[1]),
        .rsp1_data  (rsp1_data),
        .rsp1_cout  (rsp1_cout),
`ifdef ALU_ARB_STATS_EN
        .grant_cnt0 (cnt0),
        .grant_cnt1 (cnt1),
`endif
        .dbg_state  (dbg_state)
    );

`ifdef ALU_ARB_STATS_EN
    alu_arbiter #(.CNT_W(2)) u_dut_sat (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (v[0]),
        .req0_ready (sat_rdy0),
        .req0_op    (opv[0]),
        .req0_a     (av[0]),
        .req0_b     (bv[0]),
        .req1_valid (v[1]),
        .req1_ready (sat_rdy1),
        .req1_op    (opv[1]),
        .req1_a     (av[1]),
        .req1_b     (bv[1]),
        .rsp0_valid (sat_rv0),
        .rsp0_ready (rr[0]),
        .rsp0_data  (sat_d0),
        .rsp0_cout  (sat_c0),
        .rsp1_valid (sat_rv1),
        .rsp1_ready (rr[1]),
        .rsp1_data  (sat_d1),
        .rsp1_cout  (sat_c1),
        .grant_cnt0 (sat_cnt0),
        .grant_cnt1 (sat_cnt1),
        .dbg_state  (sat_dbg)
    );
`endif

    // Reference model state: pending results {cout, data} in accept order.
    logic [W:0]   exp_q[$];
    bit           m_busy;
    int           m_wait;
    int           m_owner;
    int           m_last;
    int           m_cnt[2];
    bit           acc[2];
    int           dut_acc_log[$];
    logic         obs_rdy[2], obs_rv[2], obs_cout[2];
    logic [W-1:0] obs_data[2];
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] alu_ref(input logic [1:0] op, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
        int unsigned xi, yi;
        logic [W-1:0] d;
        logic         c;
        xi = x;
        yi = y;
        case (op)
            2'd0:    begin d = W'(xi + yi); c = (xi + yi) > 32'd65535; end
            2'd1:    begin d = W'(xi - yi); c = (xi >= yi); end
            2'd2:    begin d = x & y;       c = 1'b0; end
            default: begin d = x ^ y;       c = 1'b0; end
        endcase
        return {c, d};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_busy  = 0;
        m_wait  = 0;
        m_owner = 0;
        m_last  = 1;
        m_cnt[0] = 0;
        m_cnt[1] = 0;
        acc[0] = 0;
        acc[1] = 0;
    endtask

    task automatic set_req(input int n, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b);
        v[n]   = 1'b1;
        opv[n] = op;
        av[n]  = a;
        bv[n]  = b;
    endtask

    task automatic rand_req(input int n);
        logic [W-1:0] a, b;
        a = W'($urandom);
        b = W'($urandom);
        if ($urandom_range(0, 9) == 0) a = 16'hffff;
        if ($urandom_range(0, 9) == 0) b = 16'h0000;
        set_req(n, 2'($urandom_range(0, 3)), a, b);
    endtask

    // One clock cycle: check at negedge+1, advance the model, return at posedge+1.
    task automatic cycle();
        int         win;
        logic [W:0] r;
        @(negedge clk);
        #1;
        obs_rdy[0] = req0_ready;  obs_rdy[1] = req1_ready;
        obs_rv[0]  = rsp0_valid;  obs_rv[1]  = rsp1_valid;
        obs_data[0] = rsp0_data;  obs_data[1] = rsp1_data;
        obs_cout[0] = rsp0_cout;  obs_cout[1] = rsp1_cout;
        if (v[0] && req0_ready) dut_acc_log.push_back(0);
        if (v[1] && req1_ready) dut_acc_log.push_back(1);

        win = -1;
        if (!m_busy) begin
            if (v[0] && v[1]) win = 1 - m_last;
            else if (v[0])    win = 0;
            else if (v[1])    win = 1;
        end
        check("req0_ready", req0_ready, win == 0);
        check("req1_ready", req1_ready, win == 1);
        check("rsp0_valid", rsp0_valid, m_busy && m_wait == 0 && m_owner == 0);
        check("rsp1_valid", rsp1_valid, m_busy && m_wait == 0 && m_owner == 1);
        check("rsp_exclusive", rsp0_valid & rsp1_valid, 0);
        if (m_busy && m_wait == 0 && exp_q.size() > 0) begin
            r = exp_q[0];
            check("rsp_data", obs_data[m_owner], r[W-1:0]);
            check("rsp_cout", obs_cout[m_owner], r[W]);
        end
`ifdef ALU_ARB_STATS_EN
        check("grant_cnt0", cnt0, m_cnt[0]);
        check("grant_cnt1", cnt1, m_cnt[1]);
        check("sat_cnt0", sat_cnt0, (m_cnt[0] > 3) ? 3 : m_cnt[0]);
`endif

        acc[0] = 0;
        acc[1] = 0;
        if (m_busy) begin
            if (m_wait > 0) begin
                m_wait--;
            end else if (rr[m_owner]) begin
                void'(exp_q.pop_front());
                m_busy = 0;
            end
        end else if (win >= 0) begin
            acc[win] = 1;
            exp_q.push_back(alu_ref(opv[win], av[win], bv[win]));
            m_busy  = 1;
            m_wait  = 1;
            m_owner = win;
            m_last  = win;
            if (m_cnt[win] < 65535) m_cnt[win]++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_acc(input int n, input int max_cyc);
        int k;
        k = 0;
        do begin
            cycle();
            k++;
        end while (!acc[n] && k < max_cyc);
        check("accept_in_budget", acc[n], 1);
    endtask

    task automatic drain_all();
        for (int k = 0; k < 20 && m_busy; k++) cycle();
        check("drain_in_budget", m_busy, 0);
    endtask

    task automatic do_op(input int n);
        rand_req(n);
        run_until_acc(n, 10);
        v[n]  = 1'b0;
        rr[n] = 1'b1;
        drain_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        for (int n = 0; n < 2; n++) begin
            v[n] = 0; rr[n] = 0; opv[n] = '0; av[n] = '0; bv[n] = '0;
        end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        v[0] = 1; v[1] = 1;
        #1;
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_rsp0_valid", rsp0_valid, 0);
        check("rst_rsp1_valid", rsp1_valid, 0);
        check("rst_rsp_data", rsp0_data, 0);
        check("rst_rsp_cout", rsp0_cout, 0);
        check("rst_state", dbg_state, 0);
        v[0] = 0; v[1] = 0;
        reset = 1'b1;

        // Both requesters continuously valid: strict alternation from req0.
        dut_acc_log.delete();
        rand_req(0); rand_req(1);
        rr[0] = 1; rr[1] = 1;
        for (int k = 0; k < 30 && dut_acc_log.size() < 4; k++) begin
            cycle();
            if (acc[0]) rand_req(0);
            if (acc[1]) rand_req(1);
        end
        v[0] = 0; v[1] = 0;
        check("alt_count", dut_acc_log.size(), 4);
        for (int i = 0; i < 4 && i < dut_acc_log.size(); i++) check("alt_order", dut_acc_log[i], i % 2);
        drain_all();

        // Carry-out of ffff + 1 with exact two-cycle latency.
        set_req(0, 2'b00, 16'hffff, 16'h0001);
        rr[0] = 1;
        run_until_acc(0, 10);
        v[0] = 0;
        cycle();
        check("add_exec_rv", obs_rv[0], 0);
        cycle();
        check("add_rv", obs_rv[0], 1);
        check("add_data", obs_data[0], 16'h0000);
        check("add_cout", obs_cout[0], 1);
        drain_all();

        // Reset asserted mid-EXEC drops the operation.
        rand_req(0);
        run_until_acc(0, 10);
        reset = 1'b0;
        #1;
        check("midrst_rsp0_valid", rsp0_valid, 0);
        check("midrst_rsp1_valid", rsp1_valid, 0);
        check("midrst_req0_ready", req0_ready, 0);
        check("midrst_state", dbg_state, 0);
        model_reset();
        @(negedge clk);
        #1;
        check("midrst_rsp0_hold", rsp0_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        rand_req(0);
        rr[0] = 0;
        cycle();
        check("postrst_accept", obs_rdy[0], 1);
        v[0] = 0;
        rr[0] = 1;
        drain_all();

        // Held response: stable data, req1 blocked until drain.
        set_req(0, 2'b01, 16'haa55, 16'h55aa);
        rr[0] = 0;
        run_until_acc(0, 10);
        v[0] = 0;
        rand_req(1);
        cycle();
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("hold_data", obs_data[0], 16'h54ab);
            check("hold_cout", obs_cout[0], 1);
            check("hold_req1_ready", obs_rdy[1], 0);
        end
        rr[0] = 1;
        cycle();
        cycle();
        check("after_drain_req1", obs_rdy[1], 1);
        v[1] = 0;
        rr[1] = 1;
        drain_all();

        // Lone req1 with last grant on req1.
        set_req(1, 2'b11, 16'h0001, 16'h7fff);
        run_until_acc(1, 10);
        v[1] = 0;
        rr[1] = 1;
        cycle();
        cycle();
        check("xor_rv1", obs_rv[1], 1);
        check("xor_rv0", obs_rv[0], 0);
        check("xor_data", obs_data[1], 16'h7ffe);
        check("xor_cout", obs_cout[1], 0);
        drain_all();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (acc[n] || !v[n]) begin
                    v[n] = 0;
                    if ($urandom_range(0, 99) < 45) rand_req(n);
                end else if ($urandom_range(0, 99) < 5) begin
                    v[n] = 0;
                end
                rr[n] = ($urandom_range(0, 99) < 60);
            end
            cycle();
        end
        v[0] = 0; v[1] = 0;
        rr[0] = 1; rr[1] = 1;
        drain_all();

`ifdef ALU_ARB_STATS_EN
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int k = 0; k < 3; k++) do_op(0);
        for (int k = 0; k < 2; k++) do_op(1);
        cycle();
        check("stats_cnt0_3", cnt0, 3);
        check("stats_cnt1_2", cnt1, 2);
        for (int k = 0; k < 2; k++) do_op(0);
        cycle();
        check("stats_sat_cnt0", sat_cnt0, 3);
        check("stats_cnt0_5", cnt0, 5);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
